// File: rtl/bias_stream_ctrl.sv
// ---------------------------------------------------------------------------
// bias_stream_ctrl
// Moves bias beats from the bias DMA read port into the bias FIFO feeding the
// PE array. A runtime-programmed descriptor table gives the type and output
// channel count of every layer of a frame. The block counts beats per layer,
// zeroes the unused lanes of a final partial beat, synthesises all-zero beats
// for average-pool layers, honours FIFO backpressure and can loop over frames.
//
// Ports
//   clk_data, rst_n          clock, asynchronous active-low reset
//   cfg_wr_en/addr/data      descriptor write {type[2:0], c_out}, IDLE only
//   cfg_num_layers           layers per frame, sampled on start
//   loop_en                  restart at layer 0 after the last layer
//   start                    single-cycle start pulse
//   bias_in_vld/bias_in      incoming bias beats, bias_in_rdy handshake
//   fifo_afull               FIFO has at most one free entry
//   fifo_wr_en/fifo_wr_data  registered FIFO write port
//   busy, frame_done         status; frame_done rides with the final write
//   layer_num_cur/type_cur   current layer index and effective type
//   cfg_err                  sticky configuration error
// ---------------------------------------------------------------------------
module bias_stream_ctrl #(
    parameter int BANDWIDTH  = 512,
    parameter int BITWIDTH   = 32,
    parameter int LANES      = BANDWIDTH / BITWIDTH,
    parameter int MAX_LAYERS = 64,
    parameter int LAYER_AW   = 6,
    parameter int CH_W       = 11
) (
    input  logic                  clk_data,
    input  logic                  rst_n,
    input  logic                  cfg_wr_en,
    input  logic [LAYER_AW-1:0]   cfg_wr_addr,
    input  logic [3+CH_W-1:0]     cfg_wr_data,
    input  logic [LAYER_AW:0]     cfg_num_layers,
    input  logic                  loop_en,
    input  logic                  start,
    input  logic                  bias_in_vld,
    input  logic [BANDWIDTH-1:0]  bias_in,
    output logic                  bias_in_rdy,
    input  logic                  fifo_afull,
    output logic                  fifo_wr_en,
    output logic [BANDWIDTH-1:0]  fifo_wr_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [LAYER_AW-1:0]   layer_num_cur,
    output logic [1:0]            layer_type_cur,
    output logic                  cfg_err
);

    localparam int LOG_LANES = $clog2(LANES);
    localparam int DESC_W    = 3 + CH_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_ZERO = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [DESC_W-1:0]      tbl_q [MAX_LAYERS];
    logic [LAYER_AW-1:0]    layer_q, layer_d;
    logic [LAYER_AW:0]      num_layers_q, num_layers_d;
    logic [CH_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [CH_W-1:0]        beats_m1_q, beats_m1_d;
    logic [LOG_LANES-1:0]   tail_q, tail_d;
    logic [1:0]             type_q, type_d;
    logic                   err_q, err_d;
    logic                   wr_en_q, wr_en_d;
    logic [BANDWIDTH-1:0]   wr_data_q, wr_data_d;
    logic                   frame_done_q, frame_done_d;

    logic [DESC_W-1:0]      desc_s;
    logic [CH_W-1:0]        c_out_s;
    logic [2:0]             dtype_s;
    logic [CH_W-1:0]        ceil_s;
    logic                   last_layer_s;
    logic                   last_beat_s;
    logic                   layer_end_s;

    // Zero lanes tail..LANES-1; tail of zero means the beat is full.
    function automatic logic [BANDWIDTH-1:0] mask_tail(
        input logic [BANDWIDTH-1:0] beat,
        input logic [LOG_LANES-1:0] tail
    );
        logic [BANDWIDTH-1:0] r;
        r = beat;
        for (int i = 0; i < LANES; i++) begin
            r[i*BITWIDTH +: BITWIDTH] = ((tail != '0) && (i >= int'(tail))) ?
                                        {BITWIDTH{1'b0}} : beat[i*BITWIDTH +: BITWIDTH];
        end
        return r;
    endfunction

    assign desc_s  = tbl_q[layer_q];
    assign c_out_s = desc_s[CH_W-1:0];
    assign dtype_s = desc_s[DESC_W-1:CH_W];
    // Shift-and-round-up keeps c_out = 2^CH_W-1 inside CH_W bits.
    assign ceil_s  = (c_out_s >> LOG_LANES) + CH_W'(|c_out_s[LOG_LANES-1:0]);

    assign last_layer_s = ({1'b0, layer_q} == (num_layers_q - (LAYER_AW+1)'(1'b1)));
    assign last_beat_s  = (beat_cnt_q == beats_m1_q);

    // Ready is combinational on fifo_afull so a late afull blocks the handshake.
    assign bias_in_rdy    = (state_q == S_RUN) && !fifo_afull;
    assign busy           = (state_q != S_IDLE);
    assign fifo_wr_en     = wr_en_q;
    assign fifo_wr_data   = wr_data_q;
    assign frame_done     = frame_done_q;
    assign layer_num_cur  = layer_q;
    assign layer_type_cur = type_q;
    assign cfg_err        = err_q;

    // Descriptor table: writable only while idle, cleared by reset.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tbl_q[i] <= '0;
            end
        end else if ((state_q == S_IDLE) && cfg_wr_en) begin
            tbl_q[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    // Control and output pipeline registers.
    always_ff @(posedge clk_data or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            layer_q      <= '0;
            num_layers_q <= '0;
            beat_cnt_q   <= '0;
            beats_m1_q   <= '0;
            tail_q       <= '0;
            type_q       <= 2'd0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            layer_q      <= layer_d;
            num_layers_q <= num_layers_d;
            beat_cnt_q   <= beat_cnt_d;
            beats_m1_q   <= beats_m1_d;
            tail_q       <= tail_d;
            type_q       <= type_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, beat generation and layer sequencing.
    always_comb begin
        state_d      = state_q;
        layer_d      = layer_q;
        num_layers_d = num_layers_q;
        beat_cnt_d   = beat_cnt_q;
        beats_m1_d   = beats_m1_q;
        tail_d       = tail_q;
        type_d       = type_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        layer_end_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (cfg_num_layers == '0)) begin
                    err_d = 1'b1;
                end else if (start) begin
                    num_layers_d = cfg_num_layers;
                    layer_d      = '0;
                    state_d      = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                beats_m1_d = ceil_s - CH_W'(1'b1);
                tail_d     = c_out_s[LOG_LANES-1:0];
                type_d     = (dtype_s == 3'd4) ? 2'd2 : dtype_s[1:0];
                beat_cnt_d = '0;
                if (c_out_s == '0) begin
                    // Empty layer: flag it and advance without emitting beats.
                    err_d       = 1'b1;
                    layer_end_s = 1'b1;
                end else if (dtype_s == 3'd3) begin
                    state_d = S_ZERO;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bias_in_vld && !fifo_afull) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = last_beat_s ? mask_tail(bias_in, tail_q) : bias_in;
                    layer_end_s = last_beat_s;
                    beat_cnt_d  = beat_cnt_q + CH_W'(1'b1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_ZERO: begin
                if (!fifo_afull) begin
                    wr_en_d     = 1'b1;
                    wr_data_d   = '0;
                    layer_end_s = last_beat_s;
                    beat_cnt_d  = beat_cnt_q + CH_W'(1'b1);
                end else begin
                    state_d = S_ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (layer_end_s) begin
            beat_cnt_d = '0;
            if (last_layer_s) begin
                frame_done_d = 1'b1;
                layer_d      = '0;
                state_d      = loop_en ? S_LOAD : S_IDLE;
            end else begin
                layer_d = layer_q + LAYER_AW'(1'b1);
                state_d = S_LOAD;
            end
        end else begin
            frame_done_d = 1'b0;
        end
    end

endmodule
